// File: rtl/riscv_icache_resp_pkg.sv
// Shared constants and types for the riscv instruction cache response block:
// FSM state encoding, line geometry and a line-address helper.
package riscv_icache_resp_pkg;

  localparam int unsigned LINE_BYTES     = 32;
  localparam int unsigned LINE_OFF_W     = 5;   // log2(LINE_BYTES)
  localparam int unsigned BEATS_PER_LINE = 4;   // 64-bit beats per line
  localparam int unsigned BEAT_W         = 2;   // log2(BEATS_PER_LINE)

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_REFILL = 2'd2,
    ST_RESP   = 2'd3
  } icache_state_e;

  // Line-aligned address of the line holding addr.
  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return {addr[31:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/riscv_icache_resp_if.sv
// Access bundle between the cache controller (master) and the
// tag/valid/data store (slave): one shared write port plus an async read.
interface riscv_icache_resp_if #(
  parameter int NUM_LINES_W = 4,
  parameter int TAG_W       = 23
);

  // Write port: data word write, tag set (marks line valid), single-line
  // invalidate, or whole-cache flush, all addressed by wr_index.
  logic                   data_we;
  logic                   tag_we;
  logic                   inv_en;
  logic                   flush_en;
  logic [NUM_LINES_W-1:0] wr_index;
  logic [1:0]             wr_offset;
  logic [63:0]            wr_data;
  logic [TAG_W-1:0]       wr_tag;

  // Asynchronous read port.
  logic [NUM_LINES_W-1:0] rd_index;
  logic [1:0]             rd_offset;
  logic [63:0]            rd_data;
  logic [TAG_W-1:0]       rd_tag;
  logic                   rd_valid;

  modport master (
    output data_we, tag_we, inv_en, flush_en,
    output wr_index, wr_offset, wr_data, wr_tag,
    output rd_index, rd_offset,
    input  rd_data, rd_tag, rd_valid
  );

  modport slave (
    input  data_we, tag_we, inv_en, flush_en,
    input  wr_index, wr_offset, wr_data, wr_tag,
    input  rd_index, rd_offset,
    output rd_data, rd_tag, rd_valid
  );

endinterface

// File: rtl/riscv_icache_data_ram.sv
// Direct-mapped tag/valid/data store: NUM_LINES*4 x 64 data words,
// NUM_LINES tags, one write port, asynchronous read.
module riscv_icache_data_ram
  import riscv_icache_resp_pkg::*;
#(
  parameter int NUM_LINES   = 16,
  parameter int NUM_LINES_W = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  riscv_icache_resp_if.slave   ram
);

  localparam int TAG_W = 32 - LINE_OFF_W - NUM_LINES_W;

  logic [63:0]          data_mem [NUM_LINES*BEATS_PER_LINE];
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] valid_d;

  // Next valid vector: flush clears all, invalidate clears one, tag write sets one.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    valid_d = valid_q;
    if (ram.flush_en) begin
      valid_d = '0;
    end else if (ram.inv_en) begin
      valid_d[ram.wr_index] = 1'b0;
    end else if (ram.tag_we) begin
      valid_d[ram.wr_index] = 1'b1;
    end
  end

  // Valid bits are the only state that must be cleared by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Data and tag arrays are written through the single write port.
  always_ff @(posedge clk_i) begin
    // NOTE: arrays are not reset; a line's contents are ignored until its valid bit is set.
    if (ram.data_we) begin
      data_mem[{ram.wr_index, ram.wr_offset}] <= ram.wr_data;
    end
    if (ram.tag_we) begin
      tag_mem[ram.wr_index] <= ram.wr_tag;
    end
  end

  assign ram.rd_data  = data_mem[{ram.rd_index, ram.rd_offset}];
  assign ram.rd_tag   = tag_mem[ram.rd_index];
  assign ram.rd_valid = valid_q[ram.rd_index];

endmodule

// File: rtl/riscv_icache_resp.sv
// Direct-mapped instruction cache controller: IDLE/LOOKUP/REFILL/RESP FSM,
// 4-beat line refill with error accumulation, flush and single-line invalidate.
// Optional hit/miss performance counters are built when RISCV_ICACHE_PERF_EN
// is defined; otherwise the counter ports are tied to zero.
module riscv_icache_resp
  import riscv_icache_resp_pkg::*;
#(
  parameter int NUM_LINES   = 16,
  parameter int NUM_LINES_W = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        icache_rd_i,
  input  logic        icache_flush_i,
  input  logic        icache_invalidate_i,
  input  logic [31:0] icache_pc_i,
  input  logic [1:0]  icache_priv_i,
  output logic        icache_accept_o,
  output logic        icache_valid_o,
  output logic        icache_error_o,
  output logic        icache_page_fault_o,
  output logic [63:0] icache_inst_o,

  output logic        mem_rd_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_accept_i,
  input  logic        mem_valid_i,
  input  logic        mem_error_i,
  input  logic [63:0] mem_data_i,

  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o
);

  localparam int TAG_W   = 32 - LINE_OFF_W - NUM_LINES_W;
  localparam int IDX_LSB = LINE_OFF_W;
  localparam int TAG_LSB = LINE_OFF_W + NUM_LINES_W;

  icache_state_e     state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              err_q, err_d;
  logic              mem_rd_q, mem_rd_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic              valid_q, valid_d;
  logic              error_q, error_d;
  logic [63:0]       inst_q, inst_d;
  logic              hit_inc, miss_inc;
  logic              lookup_hit;
  logic              refill_err;

  riscv_icache_resp_if #(.NUM_LINES_W(NUM_LINES_W), .TAG_W(TAG_W)) ram_if ();

  riscv_icache_data_ram #(
    .NUM_LINES   (NUM_LINES),
    .NUM_LINES_W (NUM_LINES_W)
  ) u_data_ram (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .ram   (ram_if.slave)
  );

  assign lookup_hit = ram_if.rd_valid && (ram_if.rd_tag == pc_q[31:TAG_LSB]);
  assign refill_err = err_q | mem_error_i;

  // Next-state, response and store-control decode for the cache FSM.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    beat_d     = beat_q;
    err_d      = err_q;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    valid_d    = 1'b0;
    error_d    = 1'b0;
    inst_d     = '0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;

    ram_if.data_we   = 1'b0;
    ram_if.tag_we    = 1'b0;
    ram_if.inv_en    = 1'b0;
    ram_if.flush_en  = 1'b0;
    ram_if.wr_index  = pc_q[TAG_LSB-1:IDX_LSB];
    ram_if.wr_offset = beat_q;
    ram_if.wr_data   = mem_data_i;
    ram_if.wr_tag    = pc_q[31:TAG_LSB];
    ram_if.rd_index  = pc_q[TAG_LSB-1:IDX_LSB];
    ram_if.rd_offset = pc_q[4:3];

    unique case (state_q)
      ST_IDLE: begin
        // Commands are taken here only; flush beats invalidate beats read.
        if (icache_flush_i) begin
          ram_if.flush_en = 1'b1;
        end else if (icache_invalidate_i) begin
          ram_if.inv_en   = 1'b1;
          ram_if.wr_index = icache_pc_i[TAG_LSB-1:IDX_LSB];
        end else if (icache_rd_i) begin
          pc_d    = icache_pc_i;
          state_d = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        if (lookup_hit) begin
          valid_d = 1'b1;
          inst_d  = ram_if.rd_data;
          hit_inc = 1'b1;
          state_d = ST_IDLE;
        end else begin
          // Drop the victim's valid bit now, before its data is overwritten.
          ram_if.inv_en = 1'b1;
          mem_rd_d      = 1'b1;
          mem_addr_d    = line_base(pc_q);
          beat_d        = '0;
          err_d         = 1'b0;
          miss_inc      = 1'b1;
          state_d       = ST_REFILL;
        end
      end

      ST_REFILL: begin
        if (mem_rd_q && mem_accept_i) begin
          mem_rd_d = 1'b0;
        end
        if (mem_valid_i) begin
          ram_if.data_we = 1'b1;
          beat_d         = beat_q + 1'b1;
          err_d          = refill_err;
          if (beat_q == BEAT_W'(BEATS_PER_LINE - 1)) begin
            // A line with any errored beat is never marked valid.
            ram_if.tag_we = !refill_err;
            state_d       = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        valid_d = 1'b1;
        error_d = err_q;
        inst_d  = err_q ? 64'd0 : ram_if.rd_data;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      beat_q     <= '0;
      err_q      <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      inst_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      inst_q     <= inst_d;
    end
  end

  assign icache_accept_o     = (state_q == ST_IDLE);
  assign icache_valid_o      = valid_q;
  assign icache_error_o      = error_q;
  assign icache_inst_o       = inst_q;
  assign icache_page_fault_o = 1'b0;
  assign mem_rd_o            = mem_rd_q;
  assign mem_addr_o          = mem_addr_q;

`ifdef RISCV_ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Free-running wrap-around counters of lookup outcomes.
  always_comb begin
    hit_cnt_d  = hit_cnt_q + 32'(hit_inc);
    miss_cnt_d = miss_cnt_q + 32'(miss_inc);
  end

  // Counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`else
  logic unused_perf;
  assign unused_perf  = hit_inc ^ miss_inc;
  assign hit_count_o  = '0;
  assign miss_count_o = '0;
`endif

  // Privilege and the byte offset within a 64-bit word do not affect fetch.
  logic unused_inputs;
  assign unused_inputs = ^{icache_priv_i, pc_q[2:0]};

endmodule
